// File: rtl/btn_conditioner_if.sv
// Bundle of the conditioner's tick/input strobes and per-channel outputs.
// master = the side driving tick and the raw buttons, slave = the conditioner.
interface btn_conditioner_if #(
  parameter int N_CH = 4
);
  logic              tick;
  logic [N_CH-1:0]   noisy_in;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   press;
  // 'release' is a reserved word in SystemVerilog, so the release pulse is 'rel'
  logic [N_CH-1:0]   rel;
  logic [N_CH-1:0]   rpt;
  logic              any_level;
  logic [2*N_CH-1:0] dbg_state;

  modport master (
    output tick, noisy_in,
    input  level, press, rel, rpt, any_level, dbg_state
  );

  modport slave (
    input  tick, noisy_in,
    output level, press, rel, rpt, any_level, dbg_state
  );
endinterface

// File: rtl/btn_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, tick-gated debounce,
// press/release pulses and an optional hold-to-auto-repeat generator per channel.
module btn_conditioner #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_DELAY  = 2'd1,
    RS_REPEAT = 2'd2
  } rpt_state_t;

  localparam int CW   = $clog2(STABLE_CNT);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HW   = $clog2(RMAX);

  logic [N_CH-1:0]   level_v;
  logic [N_CH-1:0]   press_v;
  logic [N_CH-1:0]   rel_v;
  logic [N_CH-1:0]   rpt_v;
  logic [2*N_CH-1:0] dbg_v;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   lvl_q;
    logic                   lvl_d;
    logic                   press_r;
    logic                   rel_r;
    logic                   rise;
    logic                   fall;

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample agreeing with the current level restarts the stability count.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (s == lvl_q) begin
        cnt_d = '0;
      end else if (bus.tick) begin
        if (cnt_q == CW'(STABLE_CNT - 1)) begin
          lvl_d = s;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    assign rise = lvl_d & ~lvl_q;
    assign fall = ~lvl_d & lvl_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.noisy_in[g]};
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_r <= rise;
        rel_r   <= fall;
      end
    end

    assign level_v[g] = lvl_q;
    assign press_v[g] = press_r;
    assign rel_v[g]   = rel_r;

    if (REPEAT_EN != 0) begin : g_rpt
      rpt_state_t    st_q;
      rpt_state_t    st_d;
      logic [HW-1:0] hcnt_q;
      logic [HW-1:0] hcnt_d;
      logic          rpt_r;
      logic          rpt_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          st_q   <= RS_IDLE;
          hcnt_q <= '0;
          rpt_r  <= 1'b0;
        end else begin
          st_q   <= st_d;
          hcnt_q <= hcnt_d;
          rpt_r  <= rpt_d;
        end
      end

      // A falling level overrides everything, including a coinciding terminal count.
      always_comb begin
        st_d   = st_q;
        hcnt_d = hcnt_q;
        rpt_d  = 1'b0;
        if (fall) begin
          st_d   = RS_IDLE;
          hcnt_d = '0;
        end else begin
          case (st_q)
            RS_IDLE: begin
              if (rise) begin
                st_d   = RS_DELAY;
                hcnt_d = '0;
              end
            end
            RS_DELAY: begin
              if (bus.tick) begin
                if (hcnt_q == HW'(REPEAT_DELAY - 1)) begin
                  rpt_d  = 1'b1;
                  hcnt_d = '0;
                  st_d   = RS_REPEAT;
                end else begin
                  hcnt_d = hcnt_q + HW'(1);
                end
              end
            end
            RS_REPEAT: begin
              if (bus.tick) begin
                if (hcnt_q == HW'(REPEAT_RATE - 1)) begin
                  rpt_d  = 1'b1;
                  hcnt_d = '0;
                end else begin
                  hcnt_d = hcnt_q + HW'(1);
                end
              end
            end
            default: begin
              st_d   = RS_IDLE;
              hcnt_d = '0;
            end
          endcase
        end
      end

      assign rpt_v[g]       = rpt_r;
      assign dbg_v[2*g +: 2] = st_q;
    end else begin : g_no_rpt
      assign rpt_v[g]       = 1'b0;
      assign dbg_v[2*g +: 2] = RS_IDLE;
    end
  end

  assign bus.level     = level_v;
  assign bus.press     = press_v;
  assign bus.rel       = rel_v;
  assign bus.rpt       = rpt_v;
  assign bus.dbg_state = dbg_v;
  assign bus.any_level = |level_v;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a vector table for steps, bounce and
// simultaneous channels, then hand-written tick-gating, auto-repeat and reset sequences.
module tb_btn_conditioner;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         tick_r;
  logic [N-1:0] noisy_r;

  int total;
  int bad;

  btn_conditioner_if #(.N_CH(N)) bus ();
  btn_conditioner_if #(.N_CH(N)) bus_nr ();

  assign bus.tick        = tick_r;
  assign bus.noisy_in    = noisy_r;
  assign bus_nr.tick     = tick_r;
  assign bus_nr.noisy_in = noisy_r;

  btn_conditioner #(.N_CH(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  btn_conditioner #(.N_CH(N), .REPEAT_EN(0)) u_dut_nr (
    .clk (clk),
    .rst (rst),
    .bus (bus_nr.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [N-1:0] noisy;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [N-1:0] n, input logic [N-1:0] l,
                              input logic [N-1:0] p, input logic [N-1:0] r,
                              input int reps);
    vec_t v;
    v.noisy = n;
    v.lvl   = l;
    v.prs   = p;
    v.rel   = r;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_main"}, {bus.level, bus.press, bus.rel, bus.rpt, bus.any_level}, '0);
    chk({name, "_nr"}, {bus_nr.level, bus_nr.press, bus_nr.rel, bus_nr.rpt, bus_nr.any_level}, '0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [16:0] exp_v;
    int rpt_cnt;
    int nr_press_cnt;
    int nr_rel_cnt;
    logic exp_r;

    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    tick_r  = 1'b1;
    noisy_r = '0;

    // Step on ch0, then release
    add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Bounce 1,0,1,1,0 on ch1, then held
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1);
    add(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0010, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    // Simultaneous step on ch2 and ch3
    add(4'b1100, 4'b0000, 4'b0000, 4'b0000, 5);
    add(4'b1100, 4'b1100, 4'b1100, 4'b0000, 1);
    add(4'b1100, 4'b1100, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b1100, 4'b0000, 4'b0000, 5);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1100, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);

    // Reset state
    edge_step();
    chk_all_zero("reset");
    chk("reset_dbg", bus.dbg_state, '0);
    edge_step();
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      noisy_r = vecs[i].noisy;
      exp_q.push_back({vecs[i].lvl, vecs[i].prs, vecs[i].rel, 4'b0000, |vecs[i].lvl});
      edge_step();
      exp_v = exp_q.pop_front();
      chk($sformatf("vec%0d", i),
          {bus.level, bus.press, bus.rel, bus.rpt, bus.any_level}, exp_v);
      chk($sformatf("vec%0d_nr", i),
          {bus_nr.level, bus_nr.press, bus_nr.rel, bus_nr.rpt, bus_nr.any_level}, exp_v);
    end

    // Tick every 10th cycle, step on ch2: level flips on the 4th tick
    for (int c = 0; c < 46; c++) begin
      tick_r  = (c % 10 == 9);
      noisy_r = 4'b0100;
      edge_step();
      chk($sformatf("tick_lvl%0d", c), bus.level, (c >= 39) ? 4'b0100 : 4'b0000);
      chk($sformatf("tick_prs%0d", c), bus.press, (c == 39) ? 4'b0100 : 4'b0000);
    end
    tick_r  = 1'b1;
    noisy_r = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      edge_step();
      chk($sformatf("tick_rel_lvl%0d", c), bus.level, (c < 5) ? 4'b0100 : 4'b0000);
      chk($sformatf("tick_rel%0d", c), bus.rel, (c == 5) ? 4'b0100 : 4'b0000);
    end

    // Auto-repeat: ch3 held 200 cycles with tick every cycle
    rpt_cnt      = 0;
    nr_press_cnt = 0;
    nr_rel_cnt   = 0;
    for (int v = 0; v < 220; v++) begin
      noisy_r = (v < 200) ? 4'b1000 : 4'b0000;
      edge_step();
      exp_r = (v >= 69) && (v < 205) && ((v - 69) % 16 == 0);
      chk($sformatf("ar_rpt%0d", v), bus.rpt, {exp_r, 3'b000});
      chk($sformatf("ar_prs%0d", v), bus.press, (v == 5) ? 4'b1000 : 4'b0000);
      chk($sformatf("ar_rel%0d", v), bus.rel, (v == 205) ? 4'b1000 : 4'b0000);
      chk($sformatf("ar_lvl%0d", v), bus.level, (v >= 5 && v < 205) ? 4'b1000 : 4'b0000);
      chk($sformatf("ar_nr_rpt%0d", v), bus_nr.rpt, 4'b0000);
      if (bus.rpt[3]) rpt_cnt++;
      if (bus_nr.press[3]) nr_press_cnt++;
      if (bus_nr.rel[3]) nr_rel_cnt++;
      if (v == 10)  chk("ar_state_delay", bus.dbg_state[7:6], 2'd1);
      if (v == 100) chk("ar_state_repeat", bus.dbg_state[7:6], 2'd2);
      if (v == 210) chk("ar_state_idle", bus.dbg_state[7:6], 2'd0);
    end
    chk("ar_rpt_total", rpt_cnt, 9);
    chk("ar_nr_press_total", nr_press_cnt, 1);
    chk("ar_nr_rel_total", nr_rel_cnt, 1);

    // Reset mid-hold while ch0 is repeating
    noisy_r = 4'b0001;
    for (int c = 0; c < 80; c++) edge_step();
    chk("mid_level_before_rst", bus.level, 4'b0001);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    edge_step();
    chk_all_zero("rst_held");
    chk("rst_held_dbg", bus.dbg_state, '0);
    rst = 1'b1;
    for (int e = 1; e <= 72; e++) begin
      edge_step();
      chk($sformatf("rr_lvl%0d", e), bus.level, (e >= 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("rr_prs%0d", e), bus.press, (e == 6) ? 4'b0001 : 4'b0000);
      chk($sformatf("rr_rpt%0d", e), bus.rpt, (e == 70) ? 4'b0001 : 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Parametrised multi-channel push-button conditioner for the board-level input path. It replaces the per-button debouncer instances with one bank, and each channel has:
- a synchroniser
- a tick-gated debounce counter
- registered press/release pulses
- an optional hold-to-auto-repeat generator

It sits between the raw `btn`/`sw` pins and the game logic, running on the fast board clock with a tick strobe from the clock divider.

Parameters:
N_CH, 4, number of independent input channels.
SYNC_STAGES, 2, synchroniser flop depth per channel (legal 2..4).
STABLE_CNT, 4, consecutive ticks of a changed level required before the debounced level flips (legal >= 2).
REPEAT_EN, 1, 1 = auto-repeat generator present; 0 = rpt tied low and repeat logic removed.
REPEAT_DELAY, 64, ticks of continuous hold before the first rpt pulse (legal >= 2).
REPEAT_RATE, 16, ticks between subsequent rpt pulses (legal >= 2).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
tick  input  1  sample strobe; counters advance only in cycles with tick=1
noisy_in  input  N_CH  raw asynchronous button levels, 1 = pressed
level  output  N_CH  debounced level per channel
press  output  N_CH  one-cycle pulse on debounced 0->1
release  output  N_CH  one-cycle pulse on debounced 1->0
rpt  output  N_CH  one-cycle auto-repeat pulse while held
any_level  output  1  OR of level

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops, debounce counters, repeat counters and FSMs clear.
  - level, press, release, rpt and any_level all drive 0.
  - After rst rises, a channel already held at 1 produces a normal press after the full latency.
- Channels are fully independent; simultaneous events on different channels produce simultaneous pulses.
- Synchroniser: SYNC_STAGES flops clocked every cycle regardless of tick. s = last stage.
- Debounce counter (width clog2(STABLE_CNT)):
  - s == level: counter clears every cycle, tick-independent.
  - s != level and tick=1:
    - counter < STABLE_CNT-1: counter increments.
    - counter == STABLE_CNT-1: level <= s and counter clears at that edge.
  - s != level and tick=0: counter holds.
- A glitch shorter than STABLE_CNT consecutive ticks never changes level; any reversion restarts the count from 0.
- Press/release are registered and asserted exactly in the first cycle level shows the new value, for one cycle only:
  - press = level & ~level_prev
  - release = ~level & level_prev
- Latency with tick=1 every cycle: input step before edge 0 -> level/press high after edge SYNC_STAGES+STABLE_CNT (default 6).
- Repeat FSM per channel (REPEAT_EN=1), states IDLE, DELAY, REPEAT, with a hold counter:
  - IDLE: on press -> DELAY, counter=0.
  - DELAY: each tick counter++. On the tick where counter==REPEAT_DELAY-1, rpt pulses next cycle, counter=0, -> REPEAT.
  - REPEAT: each tick counter++. On the tick where counter==REPEAT_RATE-1, rpt pulses next cycle and counter=0.
  - level falling (release) in any state -> IDLE, counter=0, and no rpt that cycle even if the terminal count coincides (release wins).
- rpt never coincides with press. No rpt is issued for holds shorter than REPEAT_DELAY ticks.
- tick held 0: debounce and repeat counters freeze, FSM state and level hold; synchroniser still runs.
- any_level is combinational from the level register.
- Counter widths are sized from parameters. No counter wraps: every counter clears at its terminal count.

Test Plan:
- Clean step: N_CH=4, defaults, tick=1; noisy_in=0001 at t0 -> level[0] and press[0] rise at edge 6; press[0] high for exactly 1 cycle; other channels stay 0.
- Bounce: noisy_in[1] toggles 1,0,1,1,0 (one cycle each) then held 1 -> no press during the bounce; press[1] occurs STABLE_CNT+SYNC_STAGES edges after the final rise.
- Tick gating: tick=1 every 10th cycle, step on ch2 -> level[2] rises on the 4th tick after the sync delay; counters hold between ticks.
- Auto-repeat: hold ch3 for 200 ticks with REPEAT_DELAY=64, REPEAT_RATE=16 -> one press, first rpt 64 ticks after press, then rpt every 16 ticks (total 9 rpt); on release, one release pulse and no further rpt.
- Reset mid-hold: ch0 held and repeating, rst pulled low asynchronously mid-cycle -> all outputs 0 immediately; rst high with ch0 still 1 -> fresh press after 6 edges, first rpt after 64 more ticks.
- REPEAT_EN=0 with a 200-tick hold -> rpt stays 0000 throughout; press and release unaffected.
